// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use / redirect / memory-busy hazard sequencer.
//
// It decides, each cycle, what the pipeline register controller must do, and
// reports that as a 2-bit code:
//   00 none
//   01 stall PC and IF_ID, insert a bubble into ID_EX
//   10 flush IF_ID
//   11 freeze PC through EX_MEM, no bubble
// hazType is combinational from the current inputs, the FSM state and the
// pending-flush flag. The controller samples it on the falling edge of Clk.
//
// Ports:
//   Clk, Rst_n          pipeline clock, asynchronous active-low reset
//   ID_EX_MemRead       instruction in EX is a load
//   ID_EX_Rt            load destination register
//   IF_ID_Rs, IF_ID_Rt  source registers of the instruction in ID
//   IF_ID_UsesRt        IF_ID_Rt is a true source operand
//   BranchTaken, Jump   redirect resolved or decoded this cycle
//   MemBusy             data memory not ready, the whole pipe freezes
//   hazType             hazard code (see above)
//   StallCnt, FlushCnt  saturating counts of 01/11 and 10 cycles
//
// Build option: define HAZ_PERF_CNT_EN to build the performance counters.
// Without it, StallCnt and FlushCnt are tied to zero and no counter
// registers exist.
//
// Reset release is expected to be synchronous to Clk; there is no internal
// synchronizer.

module hazard_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic             MemBusy,
  output logic [1:0]       hazType,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [1:0] HazNone   = 2'b00;
  localparam logic [1:0] HazStall  = 2'b01;
  localparam logic [1:0] HazFlush  = 2'b10;
  localparam logic [1:0] HazFreeze = 2'b11;

  // 2'b11 is unused; it is decoded by the default branch and recovers to StRun.
  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StMemWait = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic [1:0] haz_raw;

  logic load_use;
  logic redirect;

  // Register zero is hardwired, so a load into r0 never creates a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
  assign redirect = BranchTaken || Jump;

  // Next-state and hazard code. Priority in every state:
  // MemBusy > pending flush > redirect > load-use.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    haz_raw = HazNone;

    unique case (state_q)
      StRun, StMemWait: begin
        if (MemBusy) begin
          haz_raw = HazFreeze;
          state_d = StMemWait;
          // PEND is always clear in StRun, so this is PEND <= BJ there.
          pend_d  = pend_q || redirect;
        end else if (pend_q) begin
          // Deliver the redirect that arrived while the pipe was frozen.
          haz_raw = HazFlush;
          pend_d  = 1'b0;
          state_d = StRun;
        end else if (redirect) begin
          haz_raw = HazFlush;
          state_d = StRun;
        end else if (load_use) begin
          haz_raw = HazStall;
          state_d = StLuStall;
        end else begin
          haz_raw = HazNone;
          state_d = StRun;
        end
      end

      StLuStall: begin
        // ID_EX holds the bubble now, so a load-use match here is stale.
        if (MemBusy) begin
          haz_raw = HazFreeze;
          state_d = StMemWait;
          pend_d  = redirect;
        end else if (redirect) begin
          haz_raw = HazFlush;
          state_d = StRun;
        end else begin
          haz_raw = HazNone;
          state_d = StRun;
        end
      end

      default: begin
        haz_raw = HazNone;
        state_d = StRun;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StRun;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Reset overrides the code combinationally so the controller never sees a
  // stale hazard while Rst_n is low.
  assign hazType = Rst_n ? haz_raw : HazNone;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (((hazType == HazStall) || (hazType == HazFreeze)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((hazType == HazFlush) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the performance counters (Configuration).
REQ-002 Port: Clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 Port: Rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-005 Port: ID_EX_Rt  input  5  load destination register.
REQ-006 Port: IF_ID_Rs  input  5  source register of the instruction in ID.
REQ-007 Port: IF_ID_Rt  input  5  second source register of the instruction in ID.
REQ-008 Port: IF_ID_UsesRt  input  1  Rt is a true source (not a destination).
REQ-009 Port: BranchTaken  input  1  branch resolved taken this cycle.
REQ-010 Port: Jump  input  1  jump decoded this cycle.
REQ-011 Port: MemBusy  input  1  data memory not ready; the whole pipe must freeze.
REQ-012 Port: hazType  output  2  hazard code to the pipeline register controller: 00 none, 01 stall PC/IF_ID plus bubble, 10 flush IF_ID, 11 stall PC through EX_MEM with no bubble.
REQ-013 Port: StallCnt  output  CNT_W  saturating count of cycles with hazType 01 or 11 (Configuration).
REQ-014 Port: FlushCnt  output  CNT_W  saturating count of cycles with hazType 10 (Configuration).

Function
REQ-015 Load-use condition LU = ID_EX_MemRead and ID_EX_Rt != 0 and (ID_EX_Rt == IF_ID_Rs or (IF_ID_UsesRt and ID_EX_Rt == IF_ID_Rt)).
REQ-016 Redirect condition BJ = BranchTaken or Jump.
REQ-017 hazType is combinational from current inputs, FSM state, and the pending-flush flag PEND, so it is valid in the same cycle as the condition; the controller samples it on the falling edge.
REQ-018 FSM states: RUN, LU_STALL, MEM_WAIT; a 1-bit PEND register is kept alongside.
REQ-019 RUN: MemBusy gives hazType 11 and next state MEM_WAIT, with PEND <= BJ; otherwise BJ gives 10 and stays in RUN; otherwise LU gives 01 and next state LU_STALL; otherwise 00.
REQ-020 Priority in every state is MemBusy > PEND > BJ > LU.
REQ-021 LU_STALL lasts exactly one cycle, and LU is ignored in it because ID_EX holds the bubble: MemBusy gives 11 and MEM_WAIT; BJ gives 10 and RUN; else 00 and RUN.
REQ-022 MEM_WAIT with MemBusy=1 gives hazType 11 and PEND <= PEND or BJ.
REQ-023 MEM_WAIT with MemBusy=0 and PEND=1 gives hazType 10, clears PEND, and moves to RUN.
REQ-024 MEM_WAIT with MemBusy=0 and PEND=0 evaluates BJ, then LU, exactly as RUN and takes the matching next state.
REQ-025 A redirect is never lost: a BJ seen during 11 produces exactly one cycle of 10 on the first non-busy cycle.
REQ-026 A single load-use produces exactly one 01 cycle, never two consecutive 01 cycles for the same load.
REQ-027 The illegal state encoding recovers to RUN on the next edge, with hazType 00 meanwhile.

Reset
REQ-028 Rst_n low immediately forces state RUN, PEND 0, StallCnt 0, and FlushCnt 0.
REQ-029 During reset, hazType is 00 regardless of inputs.
REQ-030 Reset asserted mid-MEM_WAIT discards PEND.
REQ-031 Reset is released synchronously to Clk by the top level; there is no internal synchronizer.

Configuration
REQ-032 The macro HAZ_PERF_CNT_EN controls the performance counters.
REQ-033 With HAZ_PERF_CNT_EN defined, StallCnt and FlushCnt increment once per qualifying rising edge and saturate at all-ones.
REQ-034 Without HAZ_PERF_CNT_EN, no counter registers are built and StallCnt and FlushCnt are tied to 0; all other behaviour is identical.

Verification
REQ-035 Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 for 2 cycles -> hazType 01 then 00; state RUN->LU_STALL->RUN.
REQ-036 Register zero: ID_EX_Rt=0, IF_ID_Rs=0, MemRead=1 -> hazType stays 00.
REQ-037 Busy plus redirect: MemBusy=1 for 3 cycles with BranchTaken=1 in cycle 2 -> 11,11,11 then a single 10, then 00.
REQ-038 Priority: BranchTaken=1 and LU true in RUN -> 10, no LU_STALL entry; MemBusy=1 in the same cycle -> 11.
REQ-039 Saturation with HAZ_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> StallCnt=15; without the macro -> 0.
REQ-040 Reset mid-wait: Rst_n low during MEM_WAIT with PEND=1 -> after release with MemBusy=0, hazType 00, no flush.
